// File: rtl/rr_arb.sv
// Round-robin arbiter: searches the request vector starting at ptr_i and
// returns a one-hot grant plus its encoded index. Purely combinational.
module rr_arb #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  localparam logic [W-1:0] Last = W'(N - 1);

  logic [W-1:0] cand;

  // Walk N candidates from ptr_i, wrapping at N-1 rather than 2**W-1; first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = ptr_i;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!any_o && (cand == W'(i)) && req_i[i]) begin
          grant_o[i] = 1'b1;
          idx_o      = cand;
          any_o      = 1'b1;
        end
      end
      cand = (cand == Last) ? '0 : cand + W'(1);
    end
  end

endmodule

// File: rtl/sw_n_to_1.sv
// N-to-1 switch: round-robin merge of IN_N valid/ready sources into a single
// registered output stage that sustains one transfer per cycle.
module sw_n_to_1 #(
  parameter int unsigned IN_N  = 8,
  parameter int unsigned IN_W  = 3,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_N-1:0]         upreq_i,
  input  logic [IN_N*TAG_W-1:0]   uptag_i,
  output logic [IN_N-1:0]         uprdy_o,
  output logic                    dnreq_o,
  output logic [TAG_W-1:0]        dntag_o,
  output logic [IN_W-1:0]         dn_swb_o,
  input  logic                    dnrdy_i
);

  if ((IN_N == 0) || (IN_N > (2 ** IN_W))) begin : g_param_check
    $error("sw_n_to_1: IN_N must be in 1..2**IN_W");
  end

  localparam logic [IN_W-1:0] Last = IN_W'(IN_N - 1);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   ptr_q, ptr_d;
  logic [TAG_W-1:0]  dntag_q, dntag_d;
  logic [IN_W-1:0]   dn_swb_q, dn_swb_d;

  logic [IN_N-1:0]   grant;
  logic [IN_W-1:0]   win_idx;
  logic              win_any;
  logic [TAG_W-1:0]  win_tag;
  logic              load_en;
  logic              xfer;

  rr_arb #(
    .N (IN_N),
    .W (IN_W)
  ) u_rr_arb (
    .req_i   (upreq_i),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  // Tag mux driven by the one-hot grant, so no out-of-range select is possible.
  always_comb begin
    win_tag = '0;
    for (int unsigned i = 0; i < IN_N; i++) begin
      if (grant[i]) win_tag = uptag_i[i*TAG_W +: TAG_W];
    end
  end

  // Handshake decode: the stage can take a new item when empty or draining.
  always_comb begin
    load_en  = (state_q == StEmpty) || dnrdy_i;
    xfer     = win_any && load_en;
    uprdy_o  = grant & {IN_N{load_en}};
    dnreq_o  = (state_q == StFull);
    dntag_o  = dntag_q;
    dn_swb_o = dn_swb_q;
  end

  // Next state: load beats drain, so a simultaneous drain and load stays FULL.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    dntag_d  = dntag_q;
    dn_swb_d = dn_swb_q;
    if (xfer) begin
      state_d  = StFull;
      dntag_d  = win_tag;
      dn_swb_d = win_idx;
      ptr_d    = (win_idx == Last) ? '0 : win_idx + IN_W'(1);
    end else if (dnrdy_i) begin
      state_d = StEmpty;
    end
  end

  // State registers; reset drops any held item and restores source 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      ptr_q    <= '0;
      dntag_q  <= '0;
      dn_swb_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      dntag_q  <= dntag_d;
      dn_swb_q <= dn_swb_d;
    end
  end

endmodule

// File: tb/tb_sw_n_to_1.sv
// Scoreboard bench for sw_n_to_1: a 4-source instance and a 3-source instance.
module tb_sw_n_to_1;

  typedef struct packed {
    logic [1:0] swb;
    logic [3:0] tag;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic [3:0]  upreq4;
  logic [15:0] uptag4;
  logic [3:0]  uprdy4;
  logic        dnreq4;
  logic [3:0]  dntag4;
  logic [1:0]  dn_swb4;
  logic        dnrdy4;

  logic [2:0]  upreq3;
  logic [11:0] uptag3;
  logic [2:0]  uprdy3;
  logic        dnreq3;
  logic [3:0]  dntag3;
  logic [1:0]  dn_swb3;
  logic        dnrdy3;

  exp_t sb4[$];
  exp_t sb3[$];
  exp_t e4;
  exp_t e3;

  int n_vec;
  int n_err;

  sw_n_to_1 #(.IN_N(4), .IN_W(2), .TAG_W(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .upreq_i  (upreq4),
    .uptag_i  (uptag4),
    .uprdy_o  (uprdy4),
    .dnreq_o  (dnreq4),
    .dntag_o  (dntag4),
    .dn_swb_o (dn_swb4),
    .dnrdy_i  (dnrdy4)
  );

  sw_n_to_1 #(.IN_N(3), .IN_W(2), .TAG_W(4)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .upreq_i  (upreq3),
    .uptag_i  (uptag3),
    .uprdy_o  (uprdy3),
    .dnreq_o  (dnreq3),
    .dntag_o  (dntag3),
    .dn_swb_o (dn_swb3),
    .dnrdy_i  (dnrdy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push4(input logic [1:0] swb, input logic [3:0] tag);
    exp_t e;
    e.swb = swb;
    e.tag = tag;
    sb4.push_back(e);
  endtask

  task automatic push3(input logic [1:0] swb, input logic [3:0] tag);
    exp_t e;
    e.swb = swb;
    e.tag = tag;
    sb3.push_back(e);
  endtask

  // Monitor for the 4-source instance: every downstream transfer pops one entry.
  always @(negedge clk) begin
    if (dnreq4 && dnrdy4) begin
      if (sb4.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb4_unexpected: got swb %0d tag %0h, required no transfer", dn_swb4, dntag4);
      end else begin
        e4 = sb4.pop_front();
        check("sb4_swb", 32'(dn_swb4), 32'(e4.swb));
        check("sb4_tag", 32'(dntag4), 32'(e4.tag));
      end
    end
  end

  // Monitor for the 3-source instance.
  always @(negedge clk) begin
    if (dnreq3 && dnrdy3) begin
      if (sb3.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb3_unexpected: got swb %0d tag %0h, required no transfer", dn_swb3, dntag3);
      end else begin
        e3 = sb3.pop_front();
        check("sb3_swb", 32'(dn_swb3), 32'(e3.swb));
        check("sb3_tag", 32'(dntag3), 32'(e3.tag));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    upreq4 = 4'b1111;
    uptag4 = {4'h4, 4'h3, 4'h2, 4'h1};
    dnrdy4 = 1'b0;
    upreq3 = 3'b000;
    uptag3 = {4'hD, 4'h0, 4'hC};
    dnrdy3 = 1'b0;

    // Reset with all requests up.
    tick();
    tick();
    check("rst_dnreq", 32'(dnreq4), 32'd0);
    check("rst_uprdy", 32'(uprdy4), 32'b0001);
    check("rst_swb", 32'(dn_swb4), 32'd0);
    check("rst_tag", 32'(dntag4), 32'd0);
    check("rst_dnreq3", 32'(dnreq3), 32'd0);

    // Fairness: all four held, sink always ready.
    push4(2'd0, 4'h1);
    push4(2'd1, 4'h2);
    push4(2'd2, 4'h3);
    push4(2'd3, 4'h4);
    push4(2'd0, 4'h1);
    rst_n  = 1'b1;
    dnrdy4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("fair_full", 32'(dnreq4), 32'd1);
    end
    upreq4 = 4'b0000;
    tick();
    check("fair_drained", 32'(dnreq4), 32'd0);

    // Backpressure: item A from source 1 held for 5 cycles; ptr then 2.
    dnrdy4 = 1'b0;
    upreq4 = 4'b0010;
    uptag4 = {4'h4, 4'h3, 4'hA, 4'h1};
    push4(2'd1, 4'hA);
    tick();
    upreq4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_tag", 32'(dntag4), 32'hA);
      check("bp_uprdy", 32'(uprdy4), 32'd0);
      check("bp_dnreq", 32'(dnreq4), 32'd1);
    end
    dnrdy4 = 1'b1;
    #1;
    check("bp_ptr_grant", 32'(uprdy4), 32'b0100);
    push4(2'd2, 4'h3);
    tick();
    upreq4 = 4'b0000;
    tick();

    // Simultaneous drain and load: source 1 held, source 3 loads with no bubble.
    dnrdy4 = 1'b0;
    upreq4 = 4'b0010;
    uptag4 = {4'h8, 4'h7, 4'h6, 4'h5};
    push4(2'd1, 4'h6);
    tick();
    dnrdy4 = 1'b1;
    upreq4 = 4'b1000;
    #1;
    check("dl_uprdy", 32'(uprdy4), 32'b1000);
    push4(2'd3, 4'h8);
    tick();
    check("dl_dnreq", 32'(dnreq4), 32'd1);
    check("dl_swb", 32'(dn_swb4), 32'd3);
    upreq4 = 4'b0000;
    tick();
    dnrdy4 = 1'b0;
    upreq4 = 4'b1111;
    #1;
    check("wrap4_grant", 32'(uprdy4), 32'b0001);
    upreq4 = 4'b0000;

    // Mid-operation reset: held tag 5 is dropped, ptr returns to 0.
    uptag4 = {4'h8, 4'h5, 4'h6, 4'h5};
    upreq4 = 4'b0100;
    push4(2'd2, 4'h5);
    tick();
    upreq4 = 4'b0000;
    tick();
    check("mr_full", 32'(dnreq4), 32'd1);
    check("mr_tag_before", 32'(dntag4), 32'h5);
    rst_n = 1'b0;
    #1;
    check("mr_dnreq", 32'(dnreq4), 32'd0);
    check("mr_tag", 32'(dntag4), 32'd0);
    check("mr_swb", 32'(dn_swb4), 32'd0);
    void'(sb4.pop_back());
    upreq4 = 4'b1111;
    #1;
    check("mr_ptr", 32'(uprdy4), 32'b0001);
    upreq4 = 4'b0000;
    tick();
    rst_n  = 1'b1;
    dnrdy4 = 1'b1;
    upreq4 = 4'b0010;
    push4(2'd1, 4'h6);
    tick();
    upreq4 = 4'b0000;
    tick();

    // Wrap with IN_N=3: sources 2 and 0 alternate, index 3 never appears.
    push3(2'd2, 4'hD);
    push3(2'd0, 4'hC);
    push3(2'd2, 4'hD);
    push3(2'd0, 4'hC);
    dnrdy3 = 1'b1;
    upreq3 = 3'b100;
    tick();
    check("w3_swb_range", 32'(dn_swb3 < 2'd3), 32'd1);
    upreq3 = 3'b101;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("w3_swb_range", 32'(dn_swb3 < 2'd3), 32'd1);
      check("w3_dnreq", 32'(dnreq3), 32'd1);
    end
    upreq3 = 3'b000;
    tick();
    tick();
    tick();

    check("sb4_leftover", 32'(sb4.size()), 32'd0);
    check("sb3_leftover", 32'(sb3.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
